// File: rtl/kw_arb_pkg.sv
// Shared helpers for the weighted round-robin arbiter: pick-mode enum and
// width-generic vector functions sized to KW_MAX_N and narrowed by the caller.
package kw_arb_pkg;

  localparam int KW_MAX_N = 64;
  localparam int KW_IDX_W = 6;

  typedef enum logic {
    PICK_RR    = 1'b0,
    PICK_FIXED = 1'b1
  } pick_mode_e;

  // Rotate the low n bits of vec left by one; bits at and above n are cleared.
  function automatic logic [KW_MAX_N-1:0] rotl1(input logic [KW_MAX_N-1:0] vec, input int n);
    logic [KW_MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < KW_MAX_N; i++) begin
      if (i == n - 1) r[0] = vec[i];
      else if (i < n - 1) r[i+1] = vec[i];
    end
    return r;
  endfunction

  function automatic logic [KW_IDX_W-1:0] onehot_to_idx(input logic [KW_MAX_N-1:0] vec);
    logic [KW_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KW_MAX_N; i++) begin
      if (vec[i]) idx = idx | KW_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kw_arb_rr_pick.sv
// Combinational picker: lowest eligible index in fixed mode, otherwise the
// first eligible index at or above ptr with wraparound.
module kw_arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  input  logic         fixed,
  output logic [N-1:0] pick
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] diff2;
  logic [2*N-1:0] win2;
  logic [N-1:0]   rr_pick;
  logic [N-1:0]   fixed_pick;

  // Doubling the request vector lets the borrow chain wrap past the top index.
  assign req2       = {req, req};
  assign diff2      = req2 - {{N{1'b0}}, ptr};
  assign win2       = req2 & ~diff2;
  assign rr_pick    = win2[N-1:0] | win2[2*N-1:N];
  assign fixed_pick = req & (~req + N'(1));
  assign pick       = fixed ? fixed_pick : rr_pick;

endmodule

// File: rtl/kw_arb_wrr.sv
// Weighted round-robin arbiter: an owner keeps the grant for up to its weight in
// accepted beats (or indefinitely while locked), then ownership rotates.
module kw_arb_wrr
  import kw_arb_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    request,
  input  logic [N-1:0]    mask,
  input  logic [N-1:0]    lock,
  input  logic [N*W-1:0]  weight,
  input  logic            fixed_pri,
  input  logic            accept,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            granted,
  output logic            parked,
  output logic            locked,
  output logic [W-1:0]    quota_left
);

  logic [N-1:0] owner_q;
  logic [N-1:0] ptr_q;
  logic [W-1:0] count_q;
  logic [N-1:0] eligible;
  logic [N-1:0] pick;
  logic [W-1:0] pick_weight;
  logic [W-1:0] quota;
  logic         hold;
  pick_mode_e   mode;

  assign eligible = request & ~mask;
  assign mode     = pick_mode_e'(fixed_pri);

  kw_arb_rr_pick #(.N(N)) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .fixed (mode == PICK_FIXED),
    .pick  (pick)
  );

  // A zero weight still earns one beat so every issued turn makes progress.
  always_comb begin
    pick_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_weight = weight[i*W +: W];
    end
    quota = (pick_weight == '0) ? W'(1) : pick_weight;
  end

  assign hold = (|(owner_q & eligible)) && ((count_q != '0) || (|(owner_q & lock)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= '0;
      count_q <= '0;
      ptr_q   <= N'(1);
    end else if (hold) begin
      if (accept && (count_q != '0)) count_q <= count_q - W'(1);
    end else if (pick != '0) begin
      owner_q <= pick;
      ptr_q   <= N'(rotl1(KW_MAX_N'(pick), N));
      count_q <= quota - W'(accept);
    end else begin
      owner_q <= '0;
      count_q <= '0;
    end
  end

  assign grant      = hold ? owner_q : pick;
  assign grant_id   = ID_W'(onehot_to_idx(KW_MAX_N'(grant)));
  assign granted    = |grant;
  assign parked     = ~|eligible;
  assign locked     = |(owner_q & eligible & lock);
  assign quota_left = count_q;

  always @(posedge clock) begin
    if (!reset) begin
      assert ($onehot0(grant));
      assert ($onehot(ptr_q));
      assert ($onehot0(owner_q));
      assert ((eligible == '0) || (grant != '0));
    end
  end

endmodule
